// File: rtl/svc_pkg.sv
// Shared definitions for the service-counter system: default field widths,
// dispenser FSM encoding and the customer record handed to `top`.
package svc_pkg;

  localparam int NUM_W_DFLT   = 4;
  localparam int TIME_W_DFLT  = 4;
  localparam int TICKET_FIRST = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    HOLD = 2'd2
  } disp_state_e;

  typedef struct packed {
    logic [NUM_W_DFLT-1:0]  num;
    logic [TIME_W_DFLT-1:0] tm;
  } customer_t;

endpackage

// File: rtl/ticket_dispenser_if.sv
// Request/customer bus between the request source, the ticket dispenser and `top`.
interface ticket_dispenser_if
  import svc_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int NUM_W  = NUM_W_DFLT,
  parameter int TIME_W = TIME_W_DFLT
);

  logic                     req;
  logic [TIME_W-1:0]        req_time;
  logic                     out_valid;
  logic [NUM_W-1:0]         out_num;
  logic [TIME_W-1:0]        out_time;
  logic [$clog2(DEPTH):0]   pend_cnt;
  logic                     full;
  logic [7:0]               drop_cnt;
  logic [7:0]               rej_cnt;

  modport master (
    output req, req_time,
    input  out_valid, out_num, out_time, pend_cnt, full, drop_cnt, rej_cnt
  );

  modport slave (
    input  req, req_time,
    output out_valid, out_num, out_time, pend_cnt, full, drop_cnt, rej_cnt
  );

endinterface

// File: rtl/req_fifo.sv
// Small synchronous FIFO of pending customer entries with occupancy count.
module req_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // NOTE: storage is not reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ticket_dispenser.sv
// Ticket dispenser: numbers accepted requests, queues them and emits them to
// `top` as isolated one-cycle pulses separated by at least GAP idle cycles.
module ticket_dispenser
  import svc_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int NUM_W  = NUM_W_DFLT,
  parameter int TIME_W = TIME_W_DFLT,
  parameter int GAP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  ticket_dispenser_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(GAP) + 1;
  localparam logic [NUM_W-1:0] TKT_FIRST = NUM_W'(TICKET_FIRST);
  localparam logic [NUM_W-1:0] TKT_LAST  = '1;

  typedef struct packed {
    logic [NUM_W-1:0]  num;
    logic [TIME_W-1:0] tm;
  } entry_t;

  entry_t            wr_entry, rd_entry;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              push, pop;
  logic              req_zero, req_drop;

  disp_state_e       state_q, state_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic              out_valid_q, out_valid_d;
  logic [NUM_W-1:0]  out_num_q, out_num_d;
  logic [TIME_W-1:0] out_time_q, out_time_d;
  logic [NUM_W-1:0]  tkt_q, tkt_d;
  logic [7:0]        drop_q, drop_d;
  logic [7:0]        rej_q, rej_d;

  // A full FIFO still accepts when the FSM pops on the same edge.
  assign req_zero = bus.req && (bus.req_time == '0);
  assign req_drop = bus.req && !req_zero && fifo_full && !pop;
  assign push     = bus.req && !req_zero && !req_drop;
  assign wr_entry = '{num: tkt_q, tm: bus.req_time};

  req_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // rst_n is active-high in this codebase despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      gcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
      out_time_q  <= '0;
      tkt_q       <= TKT_FIRST;
      drop_q      <= '0;
      rej_q       <= '0;
    end else begin
      state_q     <= state_d;
      gcnt_q      <= gcnt_d;
      out_valid_q <= out_valid_d;
      out_num_q   <= out_num_d;
      out_time_q  <= out_time_d;
      tkt_q       <= tkt_d;
      drop_q      <= drop_d;
      rej_q       <= rej_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = EMIT;
      EMIT:    state_d = HOLD;
      HOLD:    if (gcnt_q == '0) state_d = fifo_empty ? IDLE : EMIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    out_valid_d = 1'b0;
    out_num_d   = '0;
    out_time_d  = '0;
    gcnt_d      = gcnt_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          out_valid_d = 1'b1;
          out_num_d   = rd_entry.num;
          out_time_d  = rd_entry.tm;
        end
      end
      EMIT: gcnt_d = GW'(GAP - 1);
      HOLD: begin
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GW'(1);
        end else if (!fifo_empty) begin
          pop         = 1'b1;
          out_valid_d = 1'b1;
          out_num_d   = rd_entry.num;
          out_time_d  = rd_entry.tm;
        end
      end
      default: ;
    endcase
  end

  // Ticket 0 is reserved as "idle" downstream, so the sequence skips it.
  always_comb begin
    tkt_d  = tkt_q;
    drop_d = drop_q;
    rej_d  = rej_q;
    if (push) tkt_d = (tkt_q == TKT_LAST) ? TKT_FIRST : tkt_q + NUM_W'(1);
    if (req_drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    if (req_zero && rej_q  != 8'hFF) rej_d  = rej_q + 8'd1;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_num   = out_num_q;
  assign bus.out_time  = out_time_q;
  assign bus.pend_cnt  = fifo_count;
  assign bus.full      = fifo_full;
  assign bus.drop_cnt  = drop_q;
  assign bus.rej_cnt   = rej_q;

endmodule
